// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus sequencer and its randomiser.
package stim_pkg;

  localparam int LFSR_W    = 32;
  localparam int CNT_W_DEF = 16;

  // Right-shifting Galois feedback mask: seed 1 steps to 0xA3000000.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'hA300_0000;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_A,
    DRAW_B,
    PRESENT,
    FINISH
  } state_t;

endpackage

// File: rtl/randomiser.sv
// 32-bit Galois LFSR that steps once per enabled cycle; reset and load restore a seed.
module randomiser
  import stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_enable,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;

  assign w_next  = r_state[0] ? ((r_state >> 1) ^ LFSR_TAPS) : (r_state >> 1);
  assign o_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_enable) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/stimulus_sequencer.sv
// Draws operand pairs from the randomiser and issues a counted run of them over valid/ready.
// States: IDLE wait start | DRAW_A/DRAW_B capture operand, step LFSR | PRESENT hold for handshake | FINISH done pulse
module stimulus_sequencer
  import stim_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_num_vectors,
  input  logic [LFSR_W-1:0] i_rng,
  output logic              o_rng_enable,
  output logic [WIDTH-1:0]  o_a,
  output logic [WIDTH-1:0]  o_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_valid;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_unused_rng;

  assign w_count_nxt  = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_unused_rng = ^i_rng;

  assign o_rng_enable = (r_state == DRAW_A) || (r_state == DRAW_B);
  assign o_busy       = (r_state != IDLE);
  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_valid      = r_valid;
  assign o_done       = r_done;
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_num   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_num_vectors != '0) begin
              r_num   <= i_num_vectors;
              r_count <= '0;
              r_state <= DRAW_A;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        DRAW_A: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            r_a     <= i_rng[WIDTH-1:0];
            r_state <= DRAW_B;
          end
        end
        DRAW_B: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            r_b     <= i_rng[WIDTH-1:0];
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          // Abort wins over a same-cycle handshake, so that pair is never counted.
          if (i_abort) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            if (r_count != r_num) begin
              r_count <= w_count_nxt;
            end
            if (w_count_nxt == r_num) begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_state <= DRAW_A;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Randomiser + sequencer pair checked against an operand-stream model of the LFSR.
module tb_stimulus_sequencer;
  import stim_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, abort = 1'b0, ready = 1'b0, load = 1'b0;
  logic [CW-1:0] num = '0;
  logic [31:0]   seed = 32'h1;
  logic [31:0]   rng, a, b;
  logic          rng_en, valid, busy, done;
  logic [CW-1:0] count;

  logic          start8 = 1'b0, abort8 = 1'b0, ready8 = 1'b0, load8 = 1'b0;
  logic [CW-1:0] num8 = '0;
  logic [31:0]   seed8 = 32'h1;
  logic [31:0]   rng8;
  logic [7:0]    a8, b8;
  logic          rng_en8, valid8, busy8, done8;
  logic [CW-1:0] count8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_lfsr  = 32'h1;
  logic [31:0] first_a, first_b, last_a, last_b;

  always #5 clk = ~clk;

  randomiser #(.SEED(32'h1)) u_rng (
    .clk(clk), .reset(reset), .i_load(load), .i_seed(seed), .i_enable(rng_en), .o_state(rng)
  );

  stimulus_sequencer #(.WIDTH(32), .CNT_W(CW)) u_seq (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort), .i_num_vectors(num),
    .i_rng(rng), .o_rng_enable(rng_en), .o_a(a), .o_b(b), .o_valid(valid),
    .i_ready(ready), .o_busy(busy), .o_done(done), .o_count(count)
  );

  randomiser #(.SEED(32'h1)) u_rng8 (
    .clk(clk), .reset(reset), .i_load(load8), .i_seed(seed8), .i_enable(rng_en8), .o_state(rng8)
  );

  stimulus_sequencer #(.WIDTH(8), .CNT_W(CW)) u_seq8 (
    .clk(clk), .reset(reset), .i_start(start8), .i_abort(abort8), .i_num_vectors(num8),
    .i_rng(rng8), .o_rng_enable(rng_en8), .o_a(a8), .o_b(b8), .o_valid(valid8),
    .i_ready(ready8), .o_busy(busy8), .o_done(done8), .o_count(count8)
  );

  // One randomiser step: divide by x, fold the feedback polynomial back in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x % 2 == 1) ? ((x / 2) ^ 32'hA300_0000) : (x / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic run_pairs(input int n, input int stall_first, input bit rand_stall,
                           input int abort_at, input bit abort_on_start);
    int k;
    int stall;
    logic [31:0] exp_a, exp_b;
    start = 1'b1;
    num   = n[CW-1:0];
    abort = abort_on_start;
    ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    k = 1;
    for (int p = 0; p < n; p++) begin
      while (!valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("valid_seen", {31'b0, valid}, 32'h1);
      chk("valid_latency", k, 3);
      exp_a  = m_lfsr;
      exp_b  = lfsr_step(exp_a);
      m_lfsr = lfsr_step(exp_b);
      chk("operand_a", a, exp_a);
      chk("operand_b", b, exp_b);
      chk("present_no_rng_en", {31'b0, rng_en}, 32'h0);
      if (p == 0) begin
        first_a = a;
        first_b = b;
      end
      last_a = a;
      last_b = b;
      if (p == abort_at) begin
        ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        abort = 1'b0;
        chk("abort_valid", {31'b0, valid}, 32'h0);
        chk("abort_count", count, p);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("abort_no_done_later", {31'b0, done}, 32'h0);
        chk("abort_count_hold", count, p);
        return;
      end
      stall = (p == 0) ? stall_first : (rand_stall ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < stall; s++) begin
        // A start raised mid-run must not relatch the vector count.
        start = (p == 0);
        num   = 16'd7;
        @(negedge clk);
        chk("stall_valid", {31'b0, valid}, 32'h1);
        chk("stall_a", a, exp_a);
        chk("stall_b", b, exp_b);
        chk("stall_rng_en", {31'b0, rng_en}, 32'h0);
      end
      start = 1'b0;
      num   = n[CW-1:0];
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      k = 1;
      chk("count_inc", count, p + 1);
      if (p == n - 1) begin
        chk("done_pulse", {31'b0, done}, 32'h1);
        chk("valid_drop", {31'b0, valid}, 32'h0);
      end else begin
        chk("no_early_done", {31'b0, done}, 32'h0);
        chk("draw_rng_en", {31'b0, rng_en}, 32'h1);
      end
    end
    @(negedge clk);
    chk("done_single", {31'b0, done}, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("final_count", count, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_a", a, 32'h0);
    chk("rst_b", b, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_count", count, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rng_en", {31'b0, rng_en}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    m_lfsr = 32'h1;
    run_pairs(2, 0, 1'b0, -1, 1'b0);
    chk("tp_first_a", first_a, 32'h0000_0001);
    chk("tp_first_b", first_b, 32'hA300_0000);
    chk("tp_second_a", last_a, 32'h5180_0000);
    chk("tp_second_b", last_b, 32'h28C0_0000);

    start = 1'b1;
    num   = '0;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done", {31'b0, done}, 32'h1);
    chk("n0_busy", {31'b0, busy}, 32'h0);
    chk("n0_rng_en", {31'b0, rng_en}, 32'h0);
    chk("n0_rng_hold", rng, m_lfsr);
    @(negedge clk);
    chk("n0_done_once", {31'b0, done}, 32'h0);
    chk("n0_rng_en2", {31'b0, rng_en}, 32'h0);

    run_pairs(3, 5, 1'b0, -1, 1'b0);

    run_pairs(3, 0, 1'b0, 1, 1'b0);
    run_pairs(1, 0, 1'b0, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      seed = $urandom | 32'h1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      m_lfsr = seed;
      run_pairs(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b1, -1, (r == 2));
    end

    start = 1'b1;
    num   = 16'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_a", a, 32'h0);
    chk("async_rst_b", b, 32'h0);
    chk("async_rst_valid", {31'b0, valid}, 32'h0);
    chk("async_rst_count", count, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_rng_en", {31'b0, rng_en}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_lfsr = 32'h1;
    run_pairs(1, 0, 1'b0, -1, 1'b0);
    chk("post_reset_a_seed", first_a, 32'h0000_0001);

    start8 = 1'b1;
    num8   = 16'd1;
    ready8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 20 && !valid8; k++) @(negedge clk);
    chk("w8_valid", {31'b0, valid8}, 32'h1);
    chk("w8_a", {24'b0, a8}, 32'h01);
    chk("w8_b", {24'b0, b8}, 32'h00);
    @(negedge clk);
    ready8 = 1'b0;
    chk("w8_done", {31'b0, done8}, 32'h1);
    chk("w8_count", count8, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stimulus_sequencer.md
Name: stimulus_sequencer

Overview:
- Controller for the 32-bit Galois LFSR randomiser in the arithmetic testbench.
- Steps the LFSR through its enable input, captures two consecutive LFSR words as operands A and B, and presents them to the DUT over a valid/ready handshake.
- Counts a programmed number of operand pairs, then signals completion.
- Sits between the randomiser (i_rng, o_rng_enable) and the DUT operand inputs.

Parameters:
- WIDTH, 32, operand width (1..32); operands are the low WIDTH bits of the LFSR word.
- CNT_W, 16, width of the vector counter and of i_num_vectors.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- i_start  input  1  start a run; sampled only in IDLE
- i_abort  input  1  terminate the current run
- i_num_vectors  input  CNT_W  number of operand pairs to issue; latched on an accepted start
- i_rng  input  32  current randomiser state
- o_rng_enable  output  1  advance the randomiser by one step this cycle
- o_a  output  WIDTH  operand A
- o_b  output  WIDTH  operand B
- o_valid  output  1  o_a and o_b are valid
- i_ready  input  1  DUT accepts the pair
- o_busy  output  1  high in any state other than IDLE
- o_done  output  1  one-cycle pulse when a run completes normally
- o_count  output  CNT_W  number of pairs accepted in the current or last run

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low. Reset forces state IDLE and all registered outputs (o_a, o_b, o_valid, o_done, o_count) to 0. The latched vector count also resets to 0.
- o_rng_enable is combinational from state. It is 0 during reset and in IDLE.
- IDLE:
  - i_start=1 with i_num_vectors≠0: latch N, clear o_count, go to DRAW_A.
  - i_start=1 with i_num_vectors=0: pulse o_done next cycle, stay in IDLE.
- DRAW_A: o_a <= i_rng[WIDTH-1:0]; o_rng_enable=1; go to DRAW_B.
- DRAW_B: o_b <= i_rng[WIDTH-1:0]; o_rng_enable=1; go to PRESENT.
- PRESENT:
  - o_valid=1, registered: it rises on entry and falls on exit.
  - o_a and o_b are held stable, and o_rng_enable=0, until the handshake.
  - On valid&&ready: o_count increments. If the new count equals N, go to FINISH; otherwise go to DRAW_A.
- FINISH: o_done=1 for exactly one cycle; go to IDLE.
- Latency:
  - First o_valid is asserted 3 cycles after an accepted start edge.
  - With i_ready tied high, back-to-back pairs are issued every 3 cycles.
- LFSR consumption: exactly 2 enables per pair. The randomiser advances 2·N steps per complete run, and its state carries over between runs (it is not reseeded).
- i_abort, any non-IDLE state: go to IDLE next cycle; o_valid drops; no o_done pulse; o_count holds its value.
  - Abort takes priority over a same-cycle handshake; that pair is not counted.
- i_start while busy: ignored.
- Simultaneous i_start and i_abort in IDLE: start is accepted; abort has no effect in IDLE.
- o_count saturates at N. A counter wrap is impossible because N ≤ 2^CNT_W − 1.
- Reset mid-run: immediate return to IDLE with the reset values above.

Decomposition:
- Package stim_pkg holds:
  - the state enum (IDLE, DRAW_A, DRAW_B, PRESENT, FINISH);
  - constant LFSR_W=32;
  - the default CNT_W.
- No sub-module inside the block. The randomiser is instantiated alongside it, not within it. The FSM and the counter stay in one module.
- The bench instantiates randomiser + stimulus_sequencer together as the reference stimulus pair.

Test Plan:
- Seed 0x00000001, N=2, i_ready=1 -> pairs (A=0x00000001, B=0xA3000000) and (A=0x51800000, B=0x28C00000). First o_valid 3 cycles after start. o_done pulses once. o_count=2.
- N=0 start -> o_done pulses the next cycle; o_busy stays 0; o_rng_enable is never asserted.
- N=3, i_ready held low 5 cycles in the first PRESENT -> o_valid held, o_a/o_b stable, no o_rng_enable. Run completes after i_ready rises; o_count=3.
- Abort asserted in PRESENT of the 2nd pair with i_ready=1 -> o_valid low the next cycle, o_count=1, no o_done. A new start resumes from the advanced LFSR state.
- reset low during DRAW_B -> all outputs 0 and state IDLE asynchronously. After release, a start with N=1 yields A=seed.
- WIDTH=8, seed 0x00000001, N=1 -> o_a=0x01, o_b=0x00 (low byte of 0xA3000000).
